// File: rtl/product_accumulator.sv
// Saturating multiply-accumulate back end: sums a batch of COUNT unsigned
// products from the 2-bit multiplier and reports the total with a done pulse.
module product_accumulator #(
    parameter int ACC_WIDTH = 8,
    parameter int COUNT     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [3:0]           prod,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] sum,
    output logic [7:0]           count,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic [7:0]           count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [7:0]           count_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // One extra bit on the adder exposes the carry used for saturation.
    always_comb begin
        sum_ext    = {1'b0, sum_q} + {{(ACC_WIDTH - 3){1'b0}}, prod};
        count_inc  = count_q + 8'd1;
        state_d    = state_q;
        sum_d      = sum_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACC;
                    sum_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ACC: begin
                if (in_valid) begin
                    count_d = count_inc;
                    if (sum_ext[ACC_WIDTH]) begin
                        sum_d      = '1;
                        overflow_d = 1'b1;
                    end else begin
                        sum_d = sum_ext[ACC_WIDTH-1:0];
                    end
                    if (count_inc == 8'(COUNT)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == ACC);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (8-bit and 5-bit sum) share
// stimulus and are checked against a batch-level reference model.
module tb_product_accumulator;

    localparam int COUNT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] prod = 4'd0;

    logic       w8_ready, w8_busy, w8_done, w8_ovf;
    logic [7:0] w8_sum, w8_count;
    logic       w5_ready, w5_busy, w5_done, w5_ovf;
    logic [4:0] w5_sum;
    logic [7:0] w5_count;

    int total = 0;
    int bad   = 0;

    // Reference model: the products accepted in the current/last batch.
    int  m_items[$];
    bit  m_active = 1'b0;
    bit  m_done   = 1'b0;

    typedef struct {
        logic       rst;
        logic       st;
        logic       vld;
        logic [3:0] prod;
        logic       sel;
        int         e_sum;
        int         e_count;
        logic       e_ready;
        logic       e_done;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[15];

    product_accumulator #(.ACC_WIDTH(8), .COUNT(COUNT)) dut8 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .prod(prod),
        .in_ready(w8_ready), .sum(w8_sum), .count(w8_count), .busy(w8_busy),
        .done(w8_done), .overflow(w8_ovf)
    );

    product_accumulator #(.ACC_WIDTH(5), .COUNT(COUNT)) dut5 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .prod(prod),
        .in_ready(w5_ready), .sum(w5_sum), .count(w5_count), .busy(w5_busy),
        .done(w5_done), .overflow(w5_ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(int rst, int st, int vld, int p, int sel,
                                 int es, int ec, int er, int ed, int eo);
        vec_t v;
        v.rst = rst[0]; v.st = st[0]; v.vld = vld[0]; v.prod = p[3:0];
        v.sel = sel[0]; v.e_sum = es; v.e_count = ec;
        v.e_ready = er[0]; v.e_done = ed[0]; v.e_ovf = eo[0];
        return v;
    endfunction

    function automatic int model_total();
        int t = 0;
        foreach (m_items[i]) t += m_items[i];
        return t;
    endfunction

    function automatic int capped(int t, int w);
        int mx = (1 << w) - 1;
        return (t > mx) ? mx : t;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelStep(input logic r, input logic s, input logic v, input logic [3:0] p);
        if (r) begin
            m_items.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_active) begin
            if (v) begin
                m_items.push_back(int'(p));
                if (m_items.size() == COUNT) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (s) begin
            m_items.delete();
            m_active = 1'b1;
        end
    endtask

    task automatic compareModel();
        int t = model_total();
        checkOutput("w8_sum",   int'(w8_sum),   capped(t, 8));
        checkOutput("w8_count", int'(w8_count), m_items.size());
        checkOutput("w8_ready", int'(w8_ready), int'(m_active));
        checkOutput("w8_busy",  int'(w8_busy),  int'(m_active | m_done));
        checkOutput("w8_done",  int'(w8_done),  int'(m_done));
        checkOutput("w8_ovf",   int'(w8_ovf),   int'(t > 255));
        checkOutput("w5_sum",   int'(w5_sum),   capped(t, 5));
        checkOutput("w5_count", int'(w5_count), m_items.size());
        checkOutput("w5_ready", int'(w5_ready), int'(m_active));
        checkOutput("w5_busy",  int'(w5_busy),  int'(m_active | m_done));
        checkOutput("w5_done",  int'(w5_done),  int'(m_done));
        checkOutput("w5_ovf",   int'(w5_ovf),   int'(t > 31));
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [3:0] p);
        reset = r; start = s; in_valid = v; prod = p;
        @(posedge clk);
        modelStep(r, s, v, p);
        #1;
        compareModel();
    endtask

    initial begin
        int done_pulses;

        vecs[0]  = mkv(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mkv(0, 1, 0, 0, 0,  0, 0, 1, 0, 0);
        vecs[2]  = mkv(0, 0, 1, 9, 0,  9, 1, 1, 0, 0);
        vecs[3]  = mkv(0, 0, 1, 6, 0, 15, 2, 1, 0, 0);
        vecs[4]  = mkv(0, 0, 1, 4, 0, 19, 3, 1, 0, 0);
        vecs[5]  = mkv(0, 0, 1, 1, 0, 20, 4, 0, 1, 0);
        vecs[6]  = mkv(0, 0, 0, 0, 0, 20, 4, 0, 0, 0);
        vecs[7]  = mkv(0, 0, 1, 5, 0, 20, 4, 0, 0, 0);
        vecs[8]  = mkv(0, 1, 0, 0, 1,  0, 0, 1, 0, 0);
        vecs[9]  = mkv(0, 0, 1, 9, 1,  9, 1, 1, 0, 0);
        vecs[10] = mkv(0, 0, 1, 9, 1, 18, 2, 1, 0, 0);
        vecs[11] = mkv(0, 0, 1, 9, 1, 27, 3, 1, 0, 0);
        vecs[12] = mkv(0, 0, 1, 9, 1, 31, 4, 0, 1, 1);
        vecs[13] = mkv(0, 0, 0, 0, 1, 31, 4, 0, 0, 1);
        vecs[14] = mkv(0, 1, 0, 0, 1,  0, 0, 1, 0, 0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].vld, vecs[i].prod);
            if (vecs[i].sel) begin
                checkOutput($sformatf("vec%0d_sum", i),   int'(w5_sum),   vecs[i].e_sum);
                checkOutput($sformatf("vec%0d_count", i), int'(w5_count), vecs[i].e_count);
                checkOutput($sformatf("vec%0d_ready", i), int'(w5_ready), int'(vecs[i].e_ready));
                checkOutput($sformatf("vec%0d_done", i),  int'(w5_done),  int'(vecs[i].e_done));
                checkOutput($sformatf("vec%0d_ovf", i),   int'(w5_ovf),   int'(vecs[i].e_ovf));
            end else begin
                checkOutput($sformatf("vec%0d_sum", i),   int'(w8_sum),   vecs[i].e_sum);
                checkOutput($sformatf("vec%0d_count", i), int'(w8_count), vecs[i].e_count);
                checkOutput($sformatf("vec%0d_ready", i), int'(w8_ready), int'(vecs[i].e_ready));
                checkOutput($sformatf("vec%0d_done", i),  int'(w8_done),  int'(vecs[i].e_done));
                checkOutput($sformatf("vec%0d_ovf", i),   int'(w8_ovf),   int'(vecs[i].e_ovf));
            end
        end

        // Stalled batch: three idle cycles delay done by exactly three steps.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd9);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'd7);
            checkOutput("stall_done", int'(w8_done), 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd6);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd4);
        checkOutput("stall_early_done", int'(w8_done), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        checkOutput("stall_done_pulse", int'(w8_done), 1);
        checkOutput("stall_sum", int'(w8_sum), 20);
        checkOutput("stall_count", int'(w8_count), 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);

        // Start in ACC and in DONE is ignored.
        done_pulses = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd3);
        checkOutput("busy_start_count", int'(w8_count), 3);
        done_pulses += int'(w8_done);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd4);
        done_pulses += int'(w8_done);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        done_pulses += int'(w8_done);
        checkOutput("busy_start_ready", int'(w8_ready), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5);
        done_pulses += int'(w8_done);
        checkOutput("busy_start_sum", int'(w8_sum), 10);
        checkOutput("busy_done_pulses", done_pulses, 1);

        // Reset mid-batch, then a fresh batch 1,2,3,4.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd8);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd8);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd8);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd8);
        checkOutput("rst_sum", int'(w8_sum), 0);
        checkOutput("rst_count", int'(w8_count), 0);
        checkOutput("rst_busy", int'(w8_busy), 0);
        checkOutput("rst_ready", int'(w8_ready), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'(i));
        checkOutput("rst_fresh_sum", int'(w8_sum), 10);
        checkOutput("rst_fresh_done", int'(w8_done), 1);

        // Randomised traffic checked against the model every cycle.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(logic'($urandom_range(0, 49) == 0),
                          logic'($urandom_range(0, 3) == 0),
                          logic'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
